// File: rtl/display_pkg.sv
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants for the multiplexed 7-segment display driver
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low cathode patterns {g,f,e,d,c,b,a}, indexed by hex value
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/scan_display_if.sv
// ============================================================================
//  Module      : scan_display_if
//  Description : Digit-select, data-load and LED drive bundle of the driver
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface scan_display_if;

    logic [7:0]  digit_sel;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        load;
    logic        scan_ce;
    logic        frame_start;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output digit_sel, data_in, dp_in, load,
        input  scan_ce, frame_start, an, seg, dp
    );

    modport slave (
        input  digit_sel, data_in, dp_in, load,
        output scan_ce, frame_start, an, seg, dp
    );

endinterface

`default_nettype wire

// File: rtl/hex_to_7seg.sv
// ============================================================================
//  Module      : hex_to_7seg
//  Description : Combinational hex nibble to active-low 7-segment decode
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_to_7seg
    import display_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output logic      [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

`default_nettype wire

// File: rtl/scan_display_driver.sv
// ============================================================================
//  Module      : scan_display_driver
//  Description : Time-multiplexed 8-digit 7-segment driver with frame-aligned
//                double-buffered data, anode dead-time and zero blanking
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    scan_display_if.slave bus
);

    localparam int            CW          = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] c_presc_max = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] c_blank     = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_presc;
    logic [CW-1:0] w_presc_next;
    logic          w_scan_ce;
    logic          w_boundary;
    logic          w_blank_next;
    logic          w_onehot;
    logic [2:0]    w_idx;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_dec;
    logic [7:0]    w_lz;

    logic [31:0]   r_shadow_data;
    logic [7:0]    r_shadow_dp;
    logic [31:0]   r_pend_data;
    logic [7:0]    r_pend_dp;
    logic          r_pend_vld;
    logic          r_frame_start;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    assign w_scan_ce    = (r_presc == c_presc_max);
    assign w_presc_next = w_scan_ce ? '0 : r_presc + 1'b1;
    assign w_boundary   = w_scan_ce & bus.digit_sel[0];
    // Outputs are registered, so blanking looks at the count they will appear under
    assign w_blank_next = (w_presc_next < c_blank);
    assign w_onehot     = (bus.digit_sel != 8'd0) &&
                          ((bus.digit_sel & (bus.digit_sel - 8'd1)) == 8'd0);

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.digit_sel[i]) w_idx = 3'(i);
        end
    end

    assign w_nibble = r_shadow_data[{w_idx, 2'b00} +: 4];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lz
            if (gi == 0) begin : g_first
                assign w_lz[gi] = 1'b0;
            end else begin : g_upper
                assign w_lz[gi] = LZ_BLANK && (r_shadow_data[31:4*gi] == '0) && !r_shadow_dp[gi];
            end
        end
    endgenerate

    hex_to_7seg u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc       <= '0;
            r_frame_start <= 1'b0;
            r_an          <= AN_OFF;
            r_seg         <= SEG_OFF;
            r_dp          <= 1'b1;
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_pend_data   <= '0;
            r_pend_dp     <= '0;
            r_pend_vld    <= 1'b0;
        end else begin
            r_presc       <= w_presc_next;
            r_frame_start <= w_boundary && (bus.load || r_pend_vld);

            // Shadow only moves on the frame boundary; a coincident load bypasses pending
            if (w_boundary && bus.load) begin
                r_shadow_data <= bus.data_in;
                r_shadow_dp   <= bus.dp_in;
                r_pend_vld    <= 1'b0;
            end else if (w_boundary && r_pend_vld) begin
                r_shadow_data <= r_pend_data;
                r_shadow_dp   <= r_pend_dp;
                r_pend_vld    <= 1'b0;
            end else if (bus.load) begin
                r_pend_data   <= bus.data_in;
                r_pend_dp     <= bus.dp_in;
                r_pend_vld    <= 1'b1;
            end

            if (w_blank_next || !w_onehot) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~bus.digit_sel;
                r_seg <= w_lz[w_idx] ? SEG_OFF : w_seg_dec;
                r_dp  <= ~r_shadow_dp[w_idx];
            end
        end
    end

    assign bus.scan_ce     = w_scan_ce;
    assign bus.frame_start = r_frame_start;
    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_scan_display_driver.sv
// ============================================================================
//  Module      : tb_scan_display_driver
//  Description : Directed bench with an attached rotate stage, 8-cycle slots
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scan_display_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scan_display_if dif ();

    logic [7:0] r_rot;
    int         r_k;
    int         r_fs_cnt = 0;
    logic       r_force_en;
    logic [7:0] r_force_val;
    int         checks   = 0;
    int         failures = 0;

    assign dif.digit_sel = r_force_en ? r_force_val : r_rot;

    // Rotate stage: bit7 first, advances on scan_ce; r_k = cycles since reset edge
    always @(posedge clk) begin
        if (reset) begin
            r_rot <= 8'h80;
            r_k   <= 0;
        end else begin
            r_k <= r_k + 1;
            if (dif.scan_ce) r_rot <= {r_rot[0], r_rot[7:1]};
        end
        if (dif.frame_start) r_fs_cnt <= r_fs_cnt + 1;
    end

    scan_display_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .LZ_BLANK     (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    // Advance to the negedge where prescaler == p and digit d is selected
    task automatic goto(input int p, input int d);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            hit = ((r_k % 8) == p) && r_rot[d];
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL goto_timeout: slot p=%0d d=%0d not reached in %0d cycles", p, d, n);
        end
    endtask

    task automatic pulse_load(input logic [31:0] data, input logic [7:0] dpv);
        dif.data_in = data;
        dif.dp_in   = dpv;
        dif.load    = 1'b1;
        @(negedge clk);
        dif.load    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dif.an !== 8'hFF) begin failures++; $display("FAIL reset_an: got %h expected ff", dif.an); end
        checks++; if (dif.seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h expected 7f", dif.seg); end
        checks++; if (dif.dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b expected 1", dif.dp); end
        checks++; if (dif.scan_ce !== 1'b0) begin failures++; $display("FAIL reset_scan_ce: got %b expected 0", dif.scan_ce); end
        checks++; if (dif.frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b expected 0", dif.frame_start); end
        reset = 1'b0;
    endtask

    task automatic test_prescaler();
        logic       exp_ce;
        logic [7:0] exp_an;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            exp_ce = ((j % 8) == 7);
            exp_an = ((j % 8) < 2) ? 8'hFF : ~r_rot;
            checks++; if (dif.scan_ce !== exp_ce) begin failures++; $display("FAIL presc_scan_ce cycle %0d: got %b expected %b", j, dif.scan_ce, exp_ce); end
            checks++; if (dif.an !== exp_an) begin failures++; $display("FAIL presc_an cycle %0d: got %h expected %h", j, dif.an, exp_an); end
            checks++; if (dif.seg !== 7'h7F) begin failures++; $display("FAIL presc_seg_blank cycle %0d: got %h expected 7f", j, dif.seg); end
        end
    endtask

    task automatic test_lz_load();
        goto(3, 4);
        pulse_load(32'h0000_00A5, 8'h00);
        goto(3, 0);
        checks++; if (dif.seg !== 7'h40) begin failures++; $display("FAIL lz_unchanged_mid_frame: got %h expected 40", dif.seg); end
        checks++; if (dif.frame_start !== 1'b0) begin failures++; $display("FAIL lz_early_frame_start: got %b expected 0", dif.frame_start); end
        goto(7, 0);
        @(negedge clk);
        checks++; if (dif.frame_start !== 1'b1) begin failures++; $display("FAIL lz_frame_start: got %b expected 1", dif.frame_start); end
        @(negedge clk);
        checks++; if (dif.frame_start !== 1'b0) begin failures++; $display("FAIL lz_frame_start_width: got %b expected 0", dif.frame_start); end
        goto(3, 7);
        checks++; if (dif.seg !== 7'h7F) begin failures++; $display("FAIL lz_digit7_seg: got %h expected 7f", dif.seg); end
        checks++; if (dif.an !== 8'h7F) begin failures++; $display("FAIL lz_digit7_an: got %h expected 7f", dif.an); end
        goto(3, 2);
        checks++; if (dif.seg !== 7'h7F) begin failures++; $display("FAIL lz_digit2_seg: got %h expected 7f", dif.seg); end
        goto(3, 1);
        checks++; if (dif.seg !== 7'h08) begin failures++; $display("FAIL lz_digit1_seg: got %h expected 08", dif.seg); end
        checks++; if (dif.an !== 8'hFD) begin failures++; $display("FAIL lz_digit1_an: got %h expected fd", dif.an); end
        goto(3, 0);
        checks++; if (dif.seg !== 7'h12) begin failures++; $display("FAIL lz_digit0_seg: got %h expected 12", dif.seg); end
        checks++; if (dif.dp !== 1'b1) begin failures++; $display("FAIL lz_digit0_dp: got %b expected 1", dif.dp); end
    endtask

    task automatic test_last_wins();
        int fs0;
        int fs1;
        goto(3, 6);
        fs0 = r_fs_cnt;
        pulse_load(32'h1111_1111, 8'h00);
        goto(3, 3);
        pulse_load(32'h2222_2222, 8'h00);
        goto(7, 0);
        repeat (2) @(negedge clk);
        fs1 = r_fs_cnt;
        checks++; if ((fs1 - fs0) !== 1) begin failures++; $display("FAIL last_wins_frame_starts: got %0d expected 1", fs1 - fs0); end
        goto(3, 7);
        checks++; if (dif.seg !== 7'h24) begin failures++; $display("FAIL last_wins_digit7: got %h expected 24", dif.seg); end
        goto(3, 0);
        checks++; if (dif.seg !== 7'h24) begin failures++; $display("FAIL last_wins_digit0: got %h expected 24", dif.seg); end
    endtask

    task automatic test_coincide();
        goto(7, 0);
        pulse_load(32'h8888_8888, 8'h80);
        checks++; if (dif.frame_start !== 1'b1) begin failures++; $display("FAIL coincide_frame_start: got %b expected 1", dif.frame_start); end
        goto(3, 7);
        checks++; if (dif.seg !== 7'h00) begin failures++; $display("FAIL coincide_digit7_seg: got %h expected 00", dif.seg); end
        checks++; if (dif.dp !== 1'b0) begin failures++; $display("FAIL coincide_digit7_dp: got %b expected 0", dif.dp); end
        goto(3, 6);
        checks++; if (dif.dp !== 1'b1) begin failures++; $display("FAIL coincide_digit6_dp: got %b expected 1", dif.dp); end
        goto(7, 0);
        @(negedge clk);
        checks++; if (dif.frame_start !== 1'b0) begin failures++; $display("FAIL coincide_pending_cleared: got %b expected 0", dif.frame_start); end
    endtask

    task automatic test_not_onehot();
        goto(3, 4);
        r_force_val = 8'b0000_0011;
        r_force_en  = 1'b1;
        @(negedge clk);
        checks++; if (dif.an !== 8'hFF) begin failures++; $display("FAIL multihot_an: got %h expected ff", dif.an); end
        checks++; if (dif.seg !== 7'h7F) begin failures++; $display("FAIL multihot_seg: got %h expected 7f", dif.seg); end
        checks++; if (dif.dp !== 1'b1) begin failures++; $display("FAIL multihot_dp: got %b expected 1", dif.dp); end
        r_force_val = 8'h00;
        @(negedge clk);
        checks++; if (dif.an !== 8'hFF) begin failures++; $display("FAIL zerosel_an: got %h expected ff", dif.an); end
        r_force_en = 1'b0;
        @(negedge clk);
        checks++; if (dif.an !== 8'hEF) begin failures++; $display("FAIL onehot_restore_an: got %h expected ef", dif.an); end
        checks++; if (dif.seg !== 7'h00) begin failures++; $display("FAIL onehot_restore_seg: got %h expected 00", dif.seg); end
    endtask

    task automatic test_reset_mid();
        goto(3, 2);
        pulse_load(32'h1234_5678, 8'hFF);
        goto(3, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (dif.an !== 8'hFF) begin failures++; $display("FAIL midreset_an: got %h expected ff", dif.an); end
        checks++; if (dif.seg !== 7'h7F) begin failures++; $display("FAIL midreset_seg: got %h expected 7f", dif.seg); end
        checks++; if (dif.dp !== 1'b1) begin failures++; $display("FAIL midreset_dp: got %b expected 1", dif.dp); end
        checks++; if (dif.scan_ce !== 1'b0) begin failures++; $display("FAIL midreset_scan_ce: got %b expected 0", dif.scan_ce); end
        reset = 1'b0;
        goto(7, 0);
        @(negedge clk);
        checks++; if (dif.frame_start !== 1'b0) begin failures++; $display("FAIL midreset_pending_discarded: got %b expected 0", dif.frame_start); end
        goto(3, 0);
        checks++; if (dif.seg !== 7'h40) begin failures++; $display("FAIL midreset_digit0_seg: got %h expected 40", dif.seg); end
        checks++; if (dif.dp !== 1'b1) begin failures++; $display("FAIL midreset_digit0_dp: got %b expected 1", dif.dp); end
        goto(3, 7);
        checks++; if (dif.seg !== 7'h7F) begin failures++; $display("FAIL midreset_digit7_seg: got %h expected 7f", dif.seg); end
    endtask

    initial begin
        reset       = 1'b1;
        dif.data_in = 32'h0;
        dif.dp_in   = 8'h0;
        dif.load    = 1'b0;
        r_force_en  = 1'b0;
        r_force_val = 8'h00;
        test_reset();
        test_prescaler();
        test_lz_load();
        test_last_wins();
        test_coincide();
        test_not_onehot();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
